// File: rtl/vga_clk_pkg.sv
// rtl/vga_clk_pkg.sv - shared constants and helpers for the programmable VGA clock divider
package vga_clk_pkg;

    localparam int unsigned MIN_DIV     = 2;
    localparam int unsigned VGA_PIX_DIV = 2;

    // clk_out stays high while the count is below this threshold
    function automatic logic [31:0] half_div(input logic [31:0] n);
        return n >> 1;
    endfunction

endpackage

// File: rtl/clk_div_prog.sv
// rtl/clk_div_prog.sv - runtime-programmable clock divider with tick enable and load handshake
module clk_div_prog
    import vga_clk_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] div_val,
    input  logic             div_load,
    output logic             div_ack,
    output logic             div_err,
    output logic             pending,
    output logic [WIDTH-1:0] active_div,
    output logic             clk_out,
    output logic             tick
);

    generate
        if (DEFAULT_DIV < int'(MIN_DIV) || DEFAULT_DIV > (2 ** WIDTH) - 1) begin : g_bad_default
            $error("clk_div_prog: DEFAULT_DIV out of range");
        end
    endgenerate

    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_active_div;
    logic [WIDTH-1:0] r_pend_div;
    logic             r_pending;
    logic             r_clk_out;
    logic             r_tick;
    logic             r_ack;
    logic             r_err;

    logic             w_wrap;
    logic             w_apply;
    logic             w_load_ok;
    logic [WIDTH-1:0] w_div_eff;
    logic [WIDTH-1:0] w_half_eff;
    logic [WIDTH-1:0] w_cnt_new;

    // The increment path is only selected when cnt < N-1, so cnt+1 never overflows
    always_comb begin
        w_wrap     = (r_cnt == r_active_div - WIDTH'(1));
        w_apply    = en && w_wrap && r_pending;
        w_load_ok  = div_load && (32'(div_val) >= MIN_DIV);
        w_div_eff  = w_apply ? r_pend_div : r_active_div;
        w_half_eff = WIDTH'(half_div(32'(w_div_eff)));
        w_cnt_new  = w_wrap ? '0 : r_cnt + WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt        <= '0;
            r_active_div <= WIDTH'(DEFAULT_DIV);
            r_pend_div   <= '0;
            r_pending    <= 1'b0;
            r_clk_out    <= 1'b0;
            r_tick       <= 1'b0;
            r_ack        <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_ack <= w_load_ok;
            r_err <= div_load && !w_load_ok;

            if (en) begin
                r_cnt     <= w_cnt_new;
                r_clk_out <= (w_cnt_new < w_half_eff);
                r_tick    <= (w_cnt_new == w_div_eff - WIDTH'(1));
            end else begin
                r_tick    <= 1'b0;
            end

            if (w_apply) begin
                r_active_div <= r_pend_div;
            end

            // A fresh accepted load wins over the apply clearing pending
            if (w_load_ok) begin
                r_pend_div <= div_val;
                r_pending  <= 1'b1;
            end else if (w_apply) begin
                r_pending  <= 1'b0;
            end
        end
    end

    assign div_ack    = r_ack;
    assign div_err    = r_err;
    assign pending    = r_pending;
    assign active_div = r_active_div;
    assign clk_out    = r_clk_out;
    assign tick       = r_tick;

endmodule

// File: tb/tb_clk_div_prog.sv
// tb/tb_clk_div_prog.sv - scoreboard bench for clk_div_prog
module tb_clk_div_prog;

    typedef struct packed {
        logic       clk_out;
        logic       tick;
        logic       ack;
        logic       err;
        logic       pend;
        logic [7:0] adiv;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [7:0] div_val;
    logic       div_load;
    logic       div_ack;
    logic       div_err;
    logic       pending;
    logic [7:0] active_div;
    logic       clk_out;
    logic       tick;

    int checks = 0;
    int errors = 0;

    exp_t q[$];

    int m_cnt, m_div, m_pdiv;
    bit m_pend;

    clk_div_prog #(.WIDTH(8), .DEFAULT_DIV(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .div_val    (div_val),
        .div_load   (div_load),
        .div_ack    (div_ack),
        .div_err    (div_err),
        .pending    (pending),
        .active_div (active_div),
        .clk_out    (clk_out),
        .tick       (tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    // Monitor: every edge that had stimulus queued is compared against its expectation
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            exp_t a;
            e = q.pop_front();
            a = '{clk_out, tick, div_ack, div_err, pending, active_div};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL sb_cycle: got clk_out=%0b tick=%0b ack=%0b err=%0b pend=%0b adiv=%0d, want clk_out=%0b tick=%0b ack=%0b err=%0b pend=%0b adiv=%0d",
                         a.clk_out, a.tick, a.ack, a.err, a.pend, a.adiv,
                         e.clk_out, e.tick, e.ack, e.err, e.pend, e.adiv);
            end
        end
    end

    task automatic model_reset();
        m_cnt  = 0;
        m_div  = 2;
        m_pdiv = 0;
        m_pend = 0;
    endtask

    task automatic step(input logic e, input logic l, input logic [7:0] v);
        exp_t x;
        bit   ok;
        bit   wrap;
        int   nd;
        int   cn;
        @(negedge clk);
        en = e; div_load = l; div_val = v;
        x = '0;
        x.clk_out = clk_out;
        ok = l && (v >= 2);
        if (e) begin
            wrap = (m_cnt == m_div - 1);
            nd = (wrap && m_pend) ? m_pdiv : m_div;
            cn = wrap ? 0 : m_cnt + 1;
            x.clk_out = (cn < nd / 2);
            x.tick = (cn == nd - 1);
            if (wrap && m_pend) begin
                m_div  = m_pdiv;
                m_pend = 0;
            end
            m_cnt = cn;
        end
        if (ok) begin
            m_pdiv = v;
            m_pend = 1;
        end
        x.ack  = ok;
        x.err  = l && !ok;
        x.pend = m_pend;
        x.adiv = 8'(m_div);
        q.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", name, act, req);
        end
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_clk_out"}, int'(clk_out), 0);
        check({name, "_tick"}, int'(tick), 0);
        check({name, "_ack"}, int'(div_ack), 0);
        check({name, "_err"}, int'(div_err), 0);
        check({name, "_pending"}, int'(pending), 0);
        check({name, "_active_div"}, int'(active_div), 2);
    endtask

    initial begin
        logic [3:0] hist_clk;
        logic [3:0] hist_tick;
        int highs;
        int ticks;
        int n;

        rst_n = 1'b0; en = 1'b0; div_load = 1'b0; div_val = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Default N=2: clk_out 0,1,0,1 and tick 1,0,1,0
        hist_clk = '0; hist_tick = '0;
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 0);
            hist_clk  = {hist_clk[2:0], clk_out};
            hist_tick = {hist_tick[2:0], tick};
        end
        check("n2_clk_pattern", int'(hist_clk), 4'b0101);
        check("n2_tick_pattern", int'(hist_tick), 4'b1010);

        // Load 5 mid-period, then measure one full 10-cycle window at N=5
        step(1, 1, 5);
        check("load5_ack", int'(div_ack), 1);
        check("load5_pending", int'(pending), 1);
        n = 0;
        while (active_div != 8'd5 && n < 10) begin
            step(1, 0, 0);
            n++;
        end
        check("load5_applied", int'(active_div), 5);
        check("load5_pend_clear", int'(pending), 0);
        highs = 0; ticks = 0;
        for (int i = 0; i < 10; i++) begin
            step(1, 0, 0);
            highs += int'(clk_out);
            ticks += int'(tick);
        end
        check("n5_high_cycles", highs, 4);
        check("n5_ticks", ticks, 2);

        // Rejected ratios
        step(1, 1, 0);
        check("load0_err", int'(div_err), 1);
        check("load0_noack", int'(div_ack), 0);
        step(1, 1, 1);
        check("load1_err", int'(div_err), 1);
        check("load1_adiv", int'(active_div), 5);
        check("load1_pending", int'(pending), 0);

        // Latest wins: 7 then 3
        step(1, 1, 7);
        step(1, 1, 3);
        for (int i = 0; i < 12; i++) step(1, 0, 0);
        check("latest_wins_adiv", int'(active_div), 3);

        // Pending 4 held while en=0
        step(1, 1, 4);
        for (int i = 0; i < 10; i++) step(0, 0, 0);
        check("frozen_pending", int'(pending), 1);
        check("frozen_tick", int'(tick), 0);
        for (int i = 0; i < 10; i++) step(1, 0, 0);
        check("after_freeze_adiv", int'(active_div), 4);

        // Loads every cycle with mixed values exercise wrap/load collisions
        for (int i = 0; i < 40; i++) step(1, (i % 3) != 1, 8'((i % 6) + 1));
        for (int i = 0; i < 20; i++) step(1, 0, 0);

        // Maximum ratio
        step(1, 1, 255);
        for (int i = 0; i < 520; i++) step(1, 0, 0);
        check("max_ratio_adiv", int'(active_div), 255);

        // N=6, pending 9, then asynchronous reset mid-period
        step(1, 1, 6);
        for (int i = 0; i < 260; i++) step(1, 0, 0);
        step(1, 1, 9);
        step(1, 0, 0);
        @(negedge clk);
        rst_n = 1'b0; en = 1'b0;
        #1;
        check_reset_vals("async_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) step(1, 0, 0);
        check("post_reset_adiv", int'(active_div), 2);

        @(negedge clk);
        en = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("sb_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
